mem_arbiter: RTL

Request arbiter and transaction sequencer in front of the byte-serial memory controller. It accepts independent requests from the instruction cache (word fetch, read-only) and the load/store buffer (load or store, byte/half/word). It issues one transaction at a time on the controller's request port, holds it until the controller signals completion, and returns read data with a one-cycle done pulse to the owner. LSB has priority, bounded by an anti-starvation counter. Pipeline flush kills in-flight instruction fetches.

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache fetches and LSB loads/stores onto the single
// memory-controller port, one transaction at a time, with LSB priority and starvation bound.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        ic_req_in,
  input  logic [31:0] ic_addr_in,
  output logic        ic_done_out,
  output logic [31:0] ic_data_out,
  input  logic        lsb_req_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_data_in,
  input  logic        lsb_r_nw_in,
  input  logic [2:0]  lsb_type_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_data_out,
  output logic [31:0] mc_addr_out,
  output logic [31:0] mc_data_out,
  output logic        mc_r_nw_out,
  output logic [2:0]  mc_type_out,
  output logic        mc_activate_out,
  input  logic [31:0] mc_data_in,
  input  logic        mc_data_available_in,
  output logic        busy_out
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state, state_n;
  logic owner, owner_n, kill, kill_n, r_nw_n, act_n;
  logic [3:0] starve, starve_n;
  logic [31:0] data, data_n, addr_n, wdata_n;
  logic [2:0] kind_n;
  logic ic_ok, lsb_win, grant;
  // a flushed icache request is invisible to arbitration in that cycle
  assign ic_ok = ic_req_in && !flush_in;
  assign lsb_win = lsb_req_in && !(ic_ok && starve == LIMIT);
  assign grant = state == IDLE && (lsb_win || ic_ok);
  always_comb begin
    state_n = state;
    owner_n = owner;
    kill_n = kill;
    starve_n = starve;
    data_n = data;
    addr_n = mc_addr_out;
    wdata_n = mc_data_out;
    r_nw_n = mc_r_nw_out;
    kind_n = mc_type_out;
    act_n = mc_activate_out;
    if (grant) begin
      state_n = BUSY;
      owner_n = lsb_win;
      kill_n = 1'b0;
      act_n = 1'b1;
      addr_n = lsb_win ? lsb_addr_in : ic_addr_in;
      wdata_n = lsb_win ? lsb_data_in : 32'd0;
      r_nw_n = lsb_win ? lsb_r_nw_in : 1'b1;
      kind_n = lsb_win ? lsb_type_in : 3'b000;
      starve_n = !lsb_win ? 4'd0 : (ic_req_in && starve != LIMIT) ? starve + 4'd1 : starve;
    end
    if (state == BUSY && mc_data_available_in) begin
      state_n = RESP;
      act_n = 1'b0;
      data_n = mc_data_in;
    end
    if (state == RESP) state_n = IDLE;
    if (state != IDLE && !owner && flush_in) kill_n = 1'b1;
    if (flush_in) starve_n = 4'd0;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      owner <= 1'b0;
      kill <= 1'b0;
      starve <= 4'd0;
      data <= 32'd0;
      mc_addr_out <= 32'd0;
      mc_data_out <= 32'd0;
      mc_r_nw_out <= 1'b0;
      mc_type_out <= 3'b000;
      mc_activate_out <= 1'b0;
    end else if (rdy_in) begin
      state <= state_n;
      owner <= owner_n;
      kill <= kill_n;
      starve <= starve_n;
      data <= data_n;
      mc_addr_out <= addr_n;
      mc_data_out <= wdata_n;
      mc_r_nw_out <= r_nw_n;
      mc_type_out <= kind_n;
      mc_activate_out <= act_n;
    end
  end
  // done is gated by rdy_in so a frozen RESP cycle cannot stretch the pulse
  assign ic_done_out = state == RESP && rdy_in && rst_in && !owner && !kill && !flush_in;
  assign lsb_done_out = state == RESP && rdy_in && rst_in && owner;
  assign ic_data_out = data;
  assign lsb_data_out = data;
  assign busy_out = state != IDLE;
endmodule
